// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, sequencer states and default widths for the ALU sequencer
package alu_pkg;

    localparam int ALU_N_DEFAULT  = 4;
    localparam int ALU_CW_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_OR  = 2'b01,
        OP_AND = 2'b10,
        OP_CAT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/acc_reg.sv
// rtl/acc_reg.sv - accumulator register with async active-low reset, sync clear and load enable
module acc_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives the external combinational ALU for a latched number of iterations
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int N  = ALU_N_DEFAULT,
    parameter int CW = ALU_CW_DEFAULT
) (
    input  logic            Clock,
    input  logic            Reset_b,
    input  logic            start,
    input  logic            clear,
    input  logic [N-1:0]    A,
    input  logic [1:0]      Function,
    input  logic [CW-1:0]   count,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [1:0]      alu_func,
    input  logic [2*N-1:0]  alu_result,
    output logic            busy,
    output logic            done,
    output logic [2*N-1:0]  ALUOut,
    output logic [N-1:0]    result_hi,
    output logic [N-1:0]    result_lo
);

    seq_state_t     state;
    seq_state_t     state_next;
    logic [N-1:0]   op_a;
    alu_op_t        op_f;
    logic [CW-1:0]  remaining;
    logic           accept;
    logic           acc_clr;
    logic           acc_load;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // start takes priority over clear, so a simultaneous clear is dropped
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        case (state)
            IDLE: acc_clr = clear && !start;
            RUN: begin
                busy     = 1'b1;
                acc_load = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            op_a      <= '0;
            op_f      <= OP_ADD;
            remaining <= '0;
        end else if (accept) begin
            op_a      <= A;
            op_f      <= alu_op_t'(Function);
            remaining <= count;
        end else if (state == RUN) begin
            remaining <= remaining - CW'(1);
        end
    end

    acc_reg #(
        .W (2 * N)
    ) u_acc (
        .clk   (Clock),
        .rst_n (Reset_b),
        .clr   (acc_clr),
        .load  (acc_load),
        .d     (alu_result),
        .q     (ALUOut)
    );

    // only the low half of the accumulator is fed back as operand B
    assign alu_a     = op_a;
    assign alu_b     = ALUOut[N-1:0];
    assign alu_func  = op_f;
    assign result_hi = ALUOut[2*N-1:N];
    assign result_lo = ALUOut[N-1:0];

endmodule
